mips_muldiv_unit: RTL and testbench

//  Iterative multiply/divide unit for the MIPS core; executes MULT, MULTU, DIV, DIVU and owns HI/LO.
//  Fed by the decode/execute stage with rs/rt operands; results read back by MFHI/MFLO.
//  The core stalls on busy_o; the unit never stalls itself.

---
 rtl/mips_muldiv_unit_pkg.sv | 27 ++
 rtl/mips_muldiv_unit_if.sv | 38 +++
 rtl/mips_muldiv_unit_div_step.sv | 33 +++
 rtl/mips_muldiv_unit.sv | 174 +++++++++++++++++
 tb/tb_mips_muldiv_unit.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/mips_muldiv_unit_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package  : mips_pkg                                                        |
// | Purpose  : Shared constants for the MIPS multiply/divide unit: operation   |
// |            encodings, muldiv FSM state encoding and the default WIDTH.     |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package mips_pkg;

  localparam int WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_MUL  = 2'b01,
    S_DIV  = 2'b10,
    S_FIX  = 2'b11
  } state_e;

endpackage
`default_nettype wire

// File: rtl/mips_muldiv_unit_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface : mips_muldiv_unit_if                                            |
// | Purpose   : Core <-> multiply/divide unit signal bundle.                   |
// | Ports     : start_i/op_i/rs_val_i/rt_val_i launch an operation;            |
// |             mthi_i/mtlo_i/wdata_i write HI/LO directly;                    |
// |             busy_o/done_o report progress; hi_o/lo_o are HI/LO.            |
// |             master = core side, slave = unit side.                         |
// | Revision  : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
interface mips_muldiv_unit_if
  import mips_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);
  logic             start_i;
  logic [1:0]       op_i;
  logic [WIDTH-1:0] rs_val_i;
  logic [WIDTH-1:0] rt_val_i;
  logic             mthi_i;
  logic             mtlo_i;
  logic [WIDTH-1:0] wdata_i;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] hi_o;
  logic [WIDTH-1:0] lo_o;

  modport master (
    output start_i, op_i, rs_val_i, rt_val_i, mthi_i, mtlo_i, wdata_i,
    input  busy_o, done_o, hi_o, lo_o
  );

  modport slave (
    input  start_i, op_i, rs_val_i, rt_val_i, mthi_i, mtlo_i, wdata_i,
    output busy_o, done_o, hi_o, lo_o
  );
endinterface
`default_nettype wire

// File: rtl/mips_muldiv_unit_div_step.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mips_div_step                                                   |
// | Purpose  : One combinational restoring-division step. Shifts the next      |
// |            dividend bit from the quotient register into the remainder,     |
// |            trial-subtracts the divisor and keeps the result if it did not  |
// |            go negative; the new quotient bit is shifted in at the bottom.  |
// | Ports    : i_rem, i_quo, i_div in; o_rem, o_quo out (all WIDTH bits).      |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module mips_div_step #(
  parameter int WIDTH = 32
) (
  input  wire logic [WIDTH-1:0] i_rem,
  input  wire logic [WIDTH-1:0] i_quo,
  input  wire logic [WIDTH-1:0] i_div,
  output logic      [WIDTH-1:0] o_rem,
  output logic      [WIDTH-1:0] o_quo
);
  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_diff;
  logic           w_ge;

  assign w_shift = {i_rem, i_quo[WIDTH-1]};
  assign w_diff  = w_shift - {1'b0, i_div};
  // The partial remainder stays below 2*divisor, so the top difference bit
  // is a reliable borrow flag (also true for a zero divisor).
  assign w_ge    = ~w_diff[WIDTH];

  assign o_rem = w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
  assign o_quo = {i_quo[WIDTH-2:0], w_ge};
endmodule
`default_nettype wire

// File: rtl/mips_muldiv_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mips_muldiv_unit                                                |
// | Purpose  : Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO. Shift-add      |
// |            multiply and restoring divide, one bit per cycle, followed by   |
// |            a sign-fix cycle that writes HI/LO and pulses done.             |
// | Ports    : clk, rst_n (async, active-low);                                 |
// |            bus (mips_muldiv_unit_if.slave): start_i, op_i, rs_val_i,       |
// |            rt_val_i, mthi_i, mtlo_i, wdata_i in; busy_o, done_o, hi_o,     |
// |            lo_o out.                                                       |
// | Config   : MULDIV_FAST_MUL_EN - single-cycle multiplier for MULT/MULTU.    |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module mips_muldiv_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  wire logic               clk,
  input  wire logic               rst_n,
  mips_muldiv_unit_if.slave       bus
);
  localparam int CW = $clog2(WIDTH);

  state_e             r_state, w_state_nxt;
  logic [CW-1:0]      r_cnt;
  // MUL: {partial product high, multiplier/low product}
  // DIV: {remainder, dividend/quotient}
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_opb;      // multiplicand or divisor magnitude
  logic               r_is_div;
  logic               r_neg_res;  // operand signs differ (signed ops only)
  logic               r_neg_rem;  // dividend negative (signed ops only)
  logic               r_dz;
  logic [WIDTH-1:0]   r_rs_orig;
  logic [WIDTH-1:0]   r_hi, r_lo;
  logic               r_done;

  logic               w_accept, w_is_div, w_signed, w_a_neg, w_b_neg;
  logic [WIDTH-1:0]   w_a_mag, w_b_mag;
  logic [WIDTH:0]     w_mul_sum;
  logic [WIDTH-1:0]   w_rem_nxt, w_quo_nxt;
  logic [2*WIDTH-1:0] w_prod, w_prod_fix;
  logic [WIDTH-1:0]   w_fix_hi, w_fix_lo;

  assign w_accept = bus.start_i && (r_state == S_IDLE);
  assign w_is_div = (bus.op_i == OP_DIV)  || (bus.op_i == OP_DIVU);
  assign w_signed = (bus.op_i == OP_MULT) || (bus.op_i == OP_DIV);
  assign w_a_neg  = w_signed && bus.rs_val_i[WIDTH-1];
  assign w_b_neg  = w_signed && bus.rt_val_i[WIDTH-1];
  assign w_a_mag  = w_a_neg ? -bus.rs_val_i : bus.rs_val_i;
  assign w_b_mag  = w_b_neg ? -bus.rt_val_i : bus.rt_val_i;

  // Shift-add: add multiplicand to the high half when the current multiplier
  // bit (acc[0]) is set, then shift the whole accumulator right by one.
  assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opb} : '0);

  mips_div_step #(.WIDTH(WIDTH)) u_div_step (
    .i_rem (r_acc[2*WIDTH-1:WIDTH]),
    .i_quo (r_acc[WIDTH-1:0]),
    .i_div (r_opb),
    .o_rem (w_rem_nxt),
    .o_quo (w_quo_nxt)
  );

`ifdef MULDIV_FAST_MUL_EN
  assign w_prod = {{WIDTH{1'b0}}, r_acc[WIDTH-1:0]} * {{WIDTH{1'b0}}, r_opb};
`else
  assign w_prod = r_acc;
`endif
  assign w_prod_fix = r_neg_res ? -w_prod : w_prod;

  always_comb begin
    w_fix_hi = w_prod_fix[2*WIDTH-1:WIDTH];
    w_fix_lo = w_prod_fix[WIDTH-1:0];
    if (r_is_div) begin
      if (r_dz) begin
        w_fix_hi = r_rs_orig;
        w_fix_lo = '1;
      end else begin
        w_fix_hi = r_neg_rem ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
        w_fix_lo = r_neg_res ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_is_div) begin
            w_state_nxt = S_DIV;
          end else begin
`ifdef MULDIV_FAST_MUL_EN
            w_state_nxt = S_FIX;
`else
            w_state_nxt = S_MUL;
`endif
          end
        end
      end
      S_MUL, S_DIV: if (r_cnt == '0) w_state_nxt = S_FIX;
      S_FIX:        w_state_nxt = S_IDLE;
      default:      w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_acc     <= '0;
      r_opb     <= '0;
      r_is_div  <= 1'b0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_dz      <= 1'b0;
      r_rs_orig <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            // A same-cycle MTHI/MTLO is dropped: the launch takes priority.
            r_cnt     <= CW'(WIDTH-1);
            r_is_div  <= w_is_div;
            r_neg_res <= w_a_neg ^ w_b_neg;
            r_neg_rem <= w_a_neg;
            r_dz      <= w_is_div && (bus.rt_val_i == '0);
            r_rs_orig <= bus.rs_val_i;
            if (w_is_div) begin
              r_acc <= {{WIDTH{1'b0}}, w_a_mag};
              r_opb <= w_b_mag;
            end else begin
              r_acc <= {{WIDTH{1'b0}}, w_b_mag};
              r_opb <= w_a_mag;
            end
          end else begin
            if (bus.mthi_i) r_hi <= bus.wdata_i;
            if (bus.mtlo_i) r_lo <= bus.wdata_i;
          end
        end
        S_MUL: begin
          r_acc <= {w_mul_sum, r_acc[WIDTH-1:1]};
          r_cnt <= r_cnt - CW'(1);
        end
        S_DIV: begin
          r_acc <= {w_rem_nxt, w_quo_nxt};
          r_cnt <= r_cnt - CW'(1);
        end
        S_FIX: begin
          r_hi   <= w_fix_hi;
          r_lo   <= w_fix_lo;
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy_o = (r_state != S_IDLE);
  assign bus.done_o = r_done;
  assign bus.hi_o   = r_hi;
  assign bus.lo_o   = r_lo;
endmodule
`default_nettype wire

// File: tb/tb_mips_muldiv_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_mips_muldiv_unit                                             |
// | Purpose  : Directed self-checking bench for mips_muldiv_unit. Expected     |
// |            HI/LO/latency are queued at launch and popped on done_o.        |
// | Config   : honours MULDIV_FAST_MUL_EN for multiply latency.                |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_mips_muldiv_unit;
  import mips_pkg::*;

  localparam int W = 32;
`ifdef MULDIV_FAST_MUL_EN
  localparam int LAT_MUL = 1;
`else
  localparam int LAT_MUL = W + 1;
`endif
  localparam int LAT_DIV = W + 1;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           lat;
    string        tag;
  } exp_t;

  exp_t sb[$];

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   t0    = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  mips_muldiv_unit_if #(.WIDTH(W)) bus ();

  mips_muldiv_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive start for one edge (T0) and queue the expected outcome.
  task automatic launch(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eh, input logic [W-1:0] el,
                        input int lat, input string tag);
    exp_t e;
    e.hi = eh; e.lo = el; e.lat = lat; e.tag = tag;
    sb.push_back(e);
    bus.op_i     = op;
    bus.rs_val_i = a;
    bus.rt_val_i = b;
    bus.start_i  = 1'b1;
    step();
    bus.start_i  = 1'b0;
    t0 = cyc;
  endtask

  task automatic await_result();
    exp_t e;
    int   n;
    n = cyc - t0;
    while (!bus.done_o && n < 200) begin
      step();
      n = cyc - t0;
    end
    if (!bus.done_o) begin
      chk("done_timeout", 64'd0, 64'd1);
      if (sb.size() > 0) void'(sb.pop_front());
    end else if (sb.size() == 0) begin
      chk("unexpected_done", 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      chk({e.tag, "_hi"},   bus.hi_o,   e.hi);
      chk({e.tag, "_lo"},   bus.lo_o,   e.lo);
      chk({e.tag, "_lat"},  n,          e.lat);
      chk({e.tag, "_busy"}, bus.busy_o, 1'b0);
    end
  endtask

  initial begin
    int seen;
    bus.start_i  = 1'b0;
    bus.op_i     = 2'b00;
    bus.rs_val_i = '0;
    bus.rt_val_i = '0;
    bus.mthi_i   = 1'b0;
    bus.mtlo_i   = 1'b0;
    bus.wdata_i  = '0;

    // Reset state
    repeat (2) step();
    chk("rst_busy", bus.busy_o, 1'b0);
    chk("rst_done", bus.done_o, 1'b0);
    chk("rst_hi",   bus.hi_o,   32'h0);
    chk("rst_lo",   bus.lo_o,   32'h0);
    rst_n = 1'b1;
    step();

    // Basic multiplies
    launch(OP_MULT, 32'd7, 32'd6, 32'h0, 32'h2A, LAT_MUL, "mult_7x6");
    chk("busy_after_start", bus.busy_o, 1'b1);
    await_result();
    step();
    chk("done_one_cycle", bus.done_o, 1'b0);

    launch(OP_MULT, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, LAT_MUL, "mult_neg3x5");
    await_result();
    launch(OP_MULTU, 32'hFFFFFFFF, 32'd2, 32'h1, 32'hFFFFFFFE, LAT_MUL, "multu_max_x2");
    await_result();
    launch(OP_MULT, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0, LAT_MUL, "mult_minxmin");
    await_result();

    // Divides, including zero divisor and the overflow corner
    launch(OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, LAT_DIV, "div_neg7_2");
    await_result();
    launch(OP_DIVU, 32'h64, 32'h0, 32'h64, 32'hFFFFFFFF, LAT_DIV, "divu_by0");
    await_result();
    launch(OP_DIV, 32'hFFFFFFF9, 32'h0, 32'hFFFFFFF9, 32'hFFFFFFFF, LAT_DIV, "div_neg_by0");
    await_result();
    launch(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, LAT_DIV, "div_min_m1");
    await_result();
    launch(OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, LAT_DIV, "divu_100_7");
    await_result();

    // start and MTHI while busy are ignored
    launch(OP_DIVU, 32'd1000, 32'd10, 32'd0, 32'd100, LAT_DIV, "divu_inject");
    repeat (4) step();
    bus.op_i     = OP_MULT;
    bus.rs_val_i = 32'd3;
    bus.rt_val_i = 32'd3;
    bus.start_i  = 1'b1;
    bus.mthi_i   = 1'b1;
    bus.wdata_i  = 32'h1234;
    step();
    bus.start_i  = 1'b0;
    bus.mthi_i   = 1'b0;
    await_result();
    step();
    chk("inject_not_queued", bus.busy_o, 1'b0);

    // MTLO / MTHI in idle
    bus.mtlo_i  = 1'b1;
    bus.wdata_i = 32'hCAFEF00D;
    step();
    bus.mtlo_i  = 1'b0;
    chk("mtlo_idle", bus.lo_o, 32'hCAFEF00D);
    bus.mthi_i  = 1'b1;
    bus.wdata_i = 32'h55;
    step();
    bus.mthi_i  = 1'b0;
    chk("mthi_idle", bus.hi_o, 32'h55);

    // Same-cycle start + MTHI: start wins, HI holds while busy
    bus.mthi_i  = 1'b1;
    bus.wdata_i = 32'hDEAD;
    launch(OP_MULTU, 32'd2, 32'd3, 32'd0, 32'd6, LAT_MUL, "multu_vs_mthi");
    bus.mthi_i  = 1'b0;
`ifndef MULDIV_FAST_MUL_EN
    chk("hi_hold_busy", bus.hi_o, 32'h55);
`endif
    await_result();
    // Back-to-back launch in the done cycle
    launch(OP_MULT, 32'hFFFFFFFD, 32'hFFFFFFFB, 32'd0, 32'd15, LAT_MUL, "mult_b2b");
    await_result();

    // Reset mid-operation aborts
    bus.mthi_i  = 1'b1;
    bus.wdata_i = 32'hA5A5;
    step();
    bus.mthi_i  = 1'b0;
`ifdef MULDIV_FAST_MUL_EN
    launch(OP_DIVU, 32'd50, 32'd5, 32'd0, 32'd10, LAT_DIV, "abort");
`else
    launch(OP_MULT, 32'd9, 32'd9, 32'd0, 32'd81, LAT_MUL, "abort");
`endif
    repeat (9) step();
    rst_n = 1'b0;
    #1;
    chk("abort_busy", bus.busy_o, 1'b0);
    chk("abort_hi",   bus.hi_o,   32'h0);
    chk("abort_lo",   bus.lo_o,   32'h0);
    sb.delete();
    step();
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      step();
      if (bus.done_o) seen++;
    end
    chk("abort_no_done", seen, 0);

    launch(OP_MULTU, 32'd3, 32'd4, 32'd0, 32'd12, LAT_MUL, "after_abort");
    await_result();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire
